cpu_regfile_seq: RTL and testbench

- Parametrised SM83 CPU register file with an integrated T-phase sequencer.
- Holds A, F, B, C, D, E, H, L, W, Z, IR, SP and PC, plus the IME flag and the EI delay.
- Provides NUM_RD byte read ports, one 16-bit pair read port and an increment/decrement unit (IDU) for 16-bit pairs.
- Generalises the flat register struct and the fixed 4-phase enum to configurable phases per M-cycle and configurable read ports.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/cpu_idu.sv | 10 +
 rtl/cpu_regfile_seq.sv | 96 +++++++++
 tb/tb_cpu_regfile_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared SM83 register-file selectors, storage type and pair mapping helpers
package cpu_types_pkg;
   typedef enum logic [3:0] {
      R_A, R_F, R_B, R_C, R_D, R_E, R_H, R_L, R_W, R_Z, R_SPH, R_SPL, R_PCH, R_PCL, R_IR
   } reg8_sel_t;
   typedef enum logic [2:0] {P_BC, P_DE, P_HL, P_WZ, P_SP, P_PC, P_AF} reg16_sel_t;
   typedef enum logic [1:0] {IDU_PASS, IDU_INC, IDU_DEC} idu_op_t;
   typedef enum logic {IME_IDLE, IME_PENDING} ime_state_t;
   typedef logic [14:0][7:0] cpu_regs_t;
   localparam logic [7:0] F_RESET = 8'hB0;
   // 4'hF marks an unmapped pair select and never matches a stored byte
   function automatic logic [3:0] hi_of(input reg16_sel_t s);
      return s == P_BC ? 4'(R_B) : s == P_DE ? 4'(R_D) : s == P_HL ? 4'(R_H) :
             s == P_WZ ? 4'(R_W) : s == P_SP ? 4'(R_SPH) : s == P_PC ? 4'(R_PCH) :
             s == P_AF ? 4'(R_A) : 4'hF;
   endfunction
   function automatic logic [3:0] lo_of(input reg16_sel_t s);
      return s == P_BC ? 4'(R_C) : s == P_DE ? 4'(R_E) : s == P_HL ? 4'(R_L) :
             s == P_WZ ? 4'(R_Z) : s == P_SP ? 4'(R_SPL) : s == P_PC ? 4'(R_PCL) :
             s == P_AF ? 4'(R_F) : 4'hF;
   endfunction
endpackage

// File: rtl/cpu_idu.sv
// cpu_idu: 16-bit combinational increment/decrement/pass unit
module cpu_idu
   import cpu_types_pkg::*;
(
   input  idu_op_t     op,
   input  logic [15:0] src,
   output logic [15:0] res
);
   always_comb res = op == IDU_INC ? src + 16'd1 : op == IDU_DEC ? src - 16'd1 : src;
endmodule

// File: rtl/cpu_regfile_seq.sv
// cpu_regfile_seq: SM83 register file with T-phase sequencer, IDU and IME/EI-delay tracking
module cpu_regfile_seq
   import cpu_types_pkg::*;
#(
   parameter int          NUM_RD    = 2,
   parameter int          PHASES    = 4,
   parameter logic [15:0] RESET_PC  = 16'h0100,
   parameter logic [15:0] RESET_SP  = 16'hFFFE,
   parameter logic [7:0]  FLAG_MASK = 8'hF0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall,
   output logic [$clog2(PHASES)-1:0]  t_phase,
   output logic                       mcycle_start,
   output logic                       mcycle_last,
   input  reg8_sel_t                  rd_sel [NUM_RD],
   output logic [7:0]                 rd_data [NUM_RD],
   input  reg16_sel_t                 rd16_sel,
   output logic [15:0]                rd16_data,
   input  logic                       wr8_en,
   input  reg8_sel_t                  wr8_sel,
   input  logic [7:0]                 wr8_data,
   input  logic                       wr16_en,
   input  reg16_sel_t                 wr16_sel,
   input  logic [15:0]                wr16_data,
   input  logic                       idu_en,
   input  idu_op_t                    idu_op,
   input  reg16_sel_t                 idu_src,
   input  reg16_sel_t                 idu_dst,
   output logic [15:0]                idu_out,
   input  logic                       ei_req,
   input  logic                       di_req,
   input  logic                       reti_req,
   input  logic                       instr_end,
   output logic                       ime,
   output logic [15:0]                pc,
   output logic [15:0]                sp
);
   localparam int TW = $clog2(PHASES);
   localparam cpu_regs_t REGS_RST = {8'h00, RESET_PC[7:0], RESET_PC[15:8], RESET_SP[7:0],
                                     RESET_SP[15:8], 64'h0, F_RESET & FLAG_MASK, 8'h01};
   cpu_regs_t   regs, nx;
   ime_state_t  state, state_nx;
   logic        ime_nx;
   logic [15:0] idu_src_val;
   function automatic logic [7:0] rd8(input reg8_sel_t s);
      return s > R_IR ? 8'h00 : s == R_F ? regs[R_F] & FLAG_MASK : regs[s];
   endfunction
   function automatic logic [15:0] rd16(input reg16_sel_t s);
      return s == P_AF ? {regs[R_A], regs[R_F] & FLAG_MASK} :
             hi_of(s) == 4'hF ? 16'h0000 : {regs[hi_of(s)], regs[lo_of(s)]};
   endfunction
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      assign rd_data[g] = rd8(rd_sel[g]);
   end
   assign rd16_data    = rd16(rd16_sel);
   assign idu_src_val  = rd16(idu_src);
   assign pc           = {regs[R_PCH], regs[R_PCL]};
   assign sp           = {regs[R_SPH], regs[R_SPL]};
   assign mcycle_start = !stall && t_phase == '0;
   assign mcycle_last  = !stall && t_phase == TW'(PHASES - 1);
   cpu_idu u_idu (.op(idu_op), .src(idu_src_val), .res(idu_out));
   // Byte-wise priority lets a wr8 override one half of a wider pair/IDU write
   always_comb begin
      nx = regs;
      for (int i = 0; i < 15; i++) begin
         nx[i] = wr8_en && 4'(wr8_sel) == 4'(i) ? wr8_data :
                 wr16_en && hi_of(wr16_sel) == 4'(i) ? wr16_data[15:8] :
                 wr16_en && lo_of(wr16_sel) == 4'(i) ? wr16_data[7:0] :
                 idu_en && hi_of(idu_dst) == 4'(i) ? idu_out[15:8] :
                 idu_en && lo_of(idu_dst) == 4'(i) ? idu_out[7:0] : regs[i];
      end
      nx[R_F] = nx[R_F] & FLAG_MASK;
   end
   // EI takes effect only after the following instruction completes
   always_comb begin
      state_nx = di_req ? IME_IDLE : ei_req ? IME_PENDING :
                 (reti_req || (state == IME_PENDING && instr_end)) ? IME_IDLE : state;
      ime_nx   = di_req ? 1'b0 :
                 (reti_req || (state == IME_PENDING && instr_end && !ei_req)) ? 1'b1 : ime;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs    <= REGS_RST;
         t_phase <= '0;
         state   <= IME_IDLE;
         ime     <= 1'b0;
      end else begin
         regs    <= nx;
         state   <= state_nx;
         ime     <= ime_nx;
         if (!stall) t_phase <= t_phase == TW'(PHASES - 1) ? '0 : t_phase + 1'b1;
      end
   end
endmodule

// File: tb/tb_cpu_regfile_seq.sv
// tb_cpu_regfile_seq: directed table-driven bench for cpu_regfile_seq with hand-written sequencer/IME sequences
module tb_cpu_regfile_seq;
   import cpu_types_pkg::*;
   typedef struct packed {
      logic        w8;
      reg8_sel_t   s8;
      logic [7:0]  d8;
      logic        w16;
      reg16_sel_t  s16;
      logic [15:0] d16;
      logic        ie;
      idu_op_t     op;
      reg16_sel_t  src;
      reg16_sel_t  dst;
      reg8_sel_t   c8;
      logic [7:0]  e8;
      reg16_sel_t  c16;
      logic [15:0] e16;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst_n, stall;
   logic [1:0]  t_phase;
   logic        mcycle_start, mcycle_last;
   reg8_sel_t   rd_sel [2];
   logic [7:0]  rd_data [2];
   reg16_sel_t  rd16_sel;
   logic [15:0] rd16_data;
   logic        wr8_en, wr16_en, idu_en;
   reg8_sel_t   wr8_sel;
   logic [7:0]  wr8_data;
   reg16_sel_t  wr16_sel, idu_src, idu_dst;
   logic [15:0] wr16_data, idu_out, pc, sp;
   idu_op_t     idu_op;
   logic        ei_req, di_req, reti_req, instr_end, ime;
   int          total = 0, passed = 0;
   vec_t        vecs [16];
   cpu_regfile_seq dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .t_phase(t_phase),
      .mcycle_start(mcycle_start), .mcycle_last(mcycle_last),
      .rd_sel(rd_sel), .rd_data(rd_data), .rd16_sel(rd16_sel), .rd16_data(rd16_data),
      .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_data(wr8_data),
      .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_data(wr16_data),
      .idu_en(idu_en), .idu_op(idu_op), .idu_src(idu_src), .idu_dst(idu_dst), .idu_out(idu_out),
      .ei_req(ei_req), .di_req(di_req), .reti_req(reti_req), .instr_end(instr_end),
      .ime(ime), .pc(pc), .sp(sp)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic ctl(input logic ei, input logic di, input logic reti, input logic ie);
      ei_req = ei; di_req = di; reti_req = reti; instr_end = ie;
      tick();
      ei_req = 0; di_req = 0; reti_req = 0; instr_end = 0;
      #1;
   endtask
   initial begin
      vecs[0]  = '{1, R_F, 8'hFF, 0, P_BC, 16'h0000, 0, IDU_PASS, P_BC, P_BC, R_F, 8'hF0, P_AF, 16'h01F0};
      vecs[1]  = '{0, R_A, 8'h00, 1, P_AF, 16'h123F, 0, IDU_PASS, P_BC, P_BC, R_A, 8'h12, P_AF, 16'h1230};
      vecs[2]  = '{0, R_A, 8'h00, 1, P_PC, 16'hFFFF, 0, IDU_PASS, P_BC, P_BC, R_PCH, 8'hFF, P_PC, 16'hFFFF};
      vecs[3]  = '{0, R_A, 8'h00, 0, P_BC, 16'h0000, 1, IDU_INC, P_PC, P_PC, R_PCL, 8'h00, P_PC, 16'h0000};
      vecs[4]  = '{0, R_A, 8'h00, 1, P_SP, 16'h0000, 0, IDU_PASS, P_BC, P_BC, R_SPH, 8'h00, P_SP, 16'h0000};
      vecs[5]  = '{0, R_A, 8'h00, 0, P_BC, 16'h0000, 1, IDU_DEC, P_SP, P_SP, R_SPL, 8'hFF, P_SP, 16'hFFFF};
      vecs[6]  = '{0, R_A, 8'h00, 1, P_HL, 16'h00FF, 0, IDU_PASS, P_BC, P_BC, R_L, 8'hFF, P_HL, 16'h00FF};
      vecs[7]  = '{1, R_L, 8'hAA, 1, P_HL, 16'h1234, 1, IDU_INC, P_HL, P_HL, R_H, 8'h12, P_HL, 16'h12AA};
      vecs[8]  = '{1, R_H, 8'h77, 0, P_BC, 16'h0000, 1, IDU_DEC, P_HL, P_HL, R_L, 8'hA9, P_HL, 16'h77A9};
      vecs[9]  = '{0, R_A, 8'h00, 1, P_HL, 16'h00FF, 0, IDU_PASS, P_BC, P_BC, R_H, 8'h00, P_HL, 16'h00FF};
      vecs[10] = '{1, R_L, 8'h5A, 0, P_BC, 16'h0000, 1, IDU_INC, P_HL, P_HL, R_H, 8'h01, P_HL, 16'h015A};
      vecs[11] = '{0, R_A, 8'h00, 0, P_BC, 16'h0000, 1, IDU_PASS, P_HL, P_WZ, R_W, 8'h01, P_WZ, 16'h015A};
      vecs[12] = '{1, R_IR, 8'h3C, 0, P_BC, 16'h0000, 0, IDU_PASS, P_BC, P_BC, R_IR, 8'h3C, P_BC, 16'h0000};
      vecs[13] = '{0, R_A, 8'h00, 1, P_BC, 16'hBEEF, 1, IDU_DEC, P_DE, P_DE, R_C, 8'hEF, P_DE, 16'hFFFF};
      vecs[14] = '{0, R_A, 8'h00, 1, P_DE, 16'h0102, 1, IDU_INC, P_DE, P_BC, R_D, 8'h01, P_BC, 16'h0000};
      vecs[15] = '{1, R_Z, 8'h22, 1, P_WZ, 16'h1111, 1, IDU_PASS, P_BC, P_WZ, R_W, 8'h11, P_WZ, 16'h1122};
      rst_n = 0; stall = 0;
      rd_sel[0] = R_A; rd_sel[1] = R_F; rd16_sel = P_AF;
      wr8_en = 0; wr8_sel = R_A; wr8_data = 0;
      wr16_en = 0; wr16_sel = P_BC; wr16_data = 0;
      idu_en = 0; idu_op = IDU_PASS; idu_src = P_BC; idu_dst = P_BC;
      ei_req = 0; di_req = 0; reti_req = 0; instr_end = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst_pc", pc, 16'h0100);
      chk("rst_sp", sp, 16'hFFFE);
      chk("rst_af", rd16_data, 16'h01B0);
      chk("rst_a", rd_data[0], 8'h01);
      chk("rst_f", rd_data[1], 8'hB0);
      chk("rst_ime", ime, 0);
      chk("ph0_t", t_phase, 0);
      chk("ph0_start", mcycle_start, 1);
      for (int c = 1; c < 9; c++) begin
         tick();
         #1;
         chk($sformatf("ph%0d_t", c), t_phase, 16'(c % 4));
         chk($sformatf("ph%0d_start", c), mcycle_start, 16'(c % 4 == 0));
         chk($sformatf("ph%0d_last", c), mcycle_last, 16'(c % 4 == 3));
      end
      tick();
      tick();
      stall = 1;
      #1;
      chk("stall0_t", t_phase, 2);
      chk("stall0_start", mcycle_start, 0);
      for (int k = 1; k < 3; k++) begin
         tick();
         #1;
         chk($sformatf("stall%0d_t", k), t_phase, 2);
         chk($sformatf("stall%0d_last", k), mcycle_last, 0);
      end
      stall = 0;
      tick();
      #1;
      chk("resume_t3", t_phase, 3);
      chk("resume_last", mcycle_last, 1);
      tick();
      #1;
      chk("resume_t0", t_phase, 0);
      chk("resume_start", mcycle_start, 1);
      for (int i = 0; i < 16; i++) begin
         wr8_en = vecs[i].w8; wr8_sel = vecs[i].s8; wr8_data = vecs[i].d8;
         wr16_en = vecs[i].w16; wr16_sel = vecs[i].s16; wr16_data = vecs[i].d16;
         idu_en = vecs[i].ie; idu_op = vecs[i].op; idu_src = vecs[i].src; idu_dst = vecs[i].dst;
         tick();
         wr8_en = 0; wr16_en = 0; idu_en = 0;
         rd_sel[0] = vecs[i].c8; rd16_sel = vecs[i].c16;
         #1;
         chk($sformatf("v%0d_rd8", i), rd_data[0], vecs[i].e8);
         chk($sformatf("v%0d_rd16", i), rd16_data, vecs[i].e16);
      end
      chk("pc_port", pc, 16'h0000);
      chk("sp_port", sp, 16'hFFFF);
      idu_op = IDU_DEC; idu_src = P_PC;
      #1;
      chk("idu_comb_dec", idu_out, 16'hFFFF);
      rd_sel[0] = R_A; rd_sel[1] = R_F;
      wr8_en = 1; wr8_sel = R_A; wr8_data = 8'h77;
      #1;
      chk("nobypass_a", rd_data[0], 8'h12);
      tick();
      wr8_en = 0;
      #1;
      chk("after_wr_a", rd_data[0], 8'h77);
      chk("f_port1", rd_data[1], 8'h30);
      ctl(1, 0, 0, 1);
      chk("ei_same_end", ime, 0);
      ctl(0, 0, 0, 1);
      chk("ei_next_end", ime, 1);
      ctl(0, 1, 0, 0);
      chk("di", ime, 0);
      ctl(1, 1, 0, 0);
      chk("ei_di_same", ime, 0);
      ctl(0, 0, 0, 1);
      chk("ei_di_no_pend", ime, 0);
      ctl(0, 0, 1, 0);
      chk("reti", ime, 1);
      ctl(0, 1, 0, 0);
      ctl(1, 0, 0, 0);
      ctl(1, 0, 0, 0);
      chk("ei_twice_wait", ime, 0);
      ctl(0, 0, 0, 1);
      chk("ei_twice_end", ime, 1);
      ctl(1, 0, 0, 0);
      wr16_en = 1; wr16_sel = P_PC; wr16_data = 16'h4321; rd16_sel = P_AF;
      #2 rst_n = 0;
      #1;
      chk("arst_pc", pc, 16'h0100);
      chk("arst_af", rd16_data, 16'h01B0);
      chk("arst_ime", ime, 0);
      chk("arst_t", t_phase, 0);
      wr16_en = 0;
      @(negedge clk);
      rst_n = 1;
      ctl(0, 0, 0, 1);
      chk("arst_no_pend", ime, 0);
      chk("arst_pc_hold", pc, 16'h0100);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
